// File: rtl/rom_ctrl_pkg.sv
// Shared definitions for the ROM controller: digest geometry, width helper and
// the hash feeder state encoding.
package rom_ctrl_pkg;

    localparam int DigestWords = 8;
    localparam int DigestWidth = DigestWords * 32;

    // Bits needed to index n items; never less than one.
    function automatic int vbits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Pairwise Hamming distance >= 3 so a single upset cannot land on a legal state.
    typedef enum logic [5:0] {
        FsHashing    = 6'b101100,
        FsReadTop    = 6'b010101,
        FsWaitDigest = 6'b011010,
        FsCompare    = 6'b100011,
        FsDone       = 6'b110000,
        FsError      = 6'b001111
    } feeder_state_e;

endpackage

// File: rtl/rom_ctrl_digest_cmp.sv
// Sequential digest comparator: while start_i is held it checks one word per
// cycle and accumulates a sticky mismatch flag.
module rom_ctrl_digest_cmp
    import rom_ctrl_pkg::*;
#(
    parameter int Words = DigestWords,
    parameter int Width = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [Words*Width-1:0]   exp_i,
    input  logic [Words*Width-1:0]   dig_i,
    output logic                     done_o,
    output logic                     match_o
);

    localparam int IdxW = vbits(Words);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

    logic [Width-1:0] exp_w [Words];
    logic [Width-1:0] dig_w [Words];

    for (genvar gi = 0; gi < Words; gi++) begin : g_split
        assign exp_w[gi] = exp_i[gi*Width +: Width];
        assign dig_w[gi] = dig_i[gi*Width +: Width];
    end

    logic [IdxW-1:0] idx_q, idx_d;
    logic            mismatch_q, mismatch_d;

    // The index saturates on the last word so it can never select past the buffer.
    always_comb begin
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        if (start_i) begin
            mismatch_d = mismatch_q | (exp_w[idx_q] != dig_w[idx_q]);
            if (idx_q != LastIdx) begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign done_o  = start_i && (idx_q == LastIdx);
    assign match_o = ~mismatch_q;

endmodule

// File: rtl/rom_ctrl_hash_feeder.sv
// Streams non-top ROM words to KMAC, captures the top words as the expected
// digest, then compares it against the KMAC digest and reports the verdict.
module rom_ctrl_hash_feeder
    import rom_ctrl_pkg::*;
#(
    parameter int RomDepth    = 16,
    parameter int RomTopCount = DigestWords,
    parameter int DataWidth   = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [DataWidth-1:0]             rom_data_i,
    input  logic                             rom_vld_i,
    input  logic [vbits(RomDepth)-1:0]       data_addr_i,
    input  logic                             data_last_nontop_i,
    input  logic                             ctr_done_i,
    output logic                             data_rdy_o,
    output logic                             kmac_vld_o,
    output logic [DataWidth-1:0]             kmac_data_o,
    output logic                             kmac_last_o,
    input  logic                             kmac_rdy_i,
    input  logic                             kmac_digest_vld_i,
    input  logic [RomTopCount*DataWidth-1:0] kmac_digest_i,
    output logic                             done_o,
    output logic                             good_o,
    output logic                             alert_o
);

    localparam int AddrW = vbits(RomDepth);
    localparam logic [AddrW-1:0] TopStart = AddrW'(RomDepth - RomTopCount);

    feeder_state_e state_q, state_d;

    logic [RomTopCount-1:0][DataWidth-1:0] exp_q;
    logic [RomTopCount*DataWidth-1:0]      dig_q;
    logic                                  dig_valid_q;
    logic                                  ctr_done_seen_q;

    logic                   capture_en;
    logic                   dig_accept;
    logic                   cmp_start;
    logic                   cmp_done;
    logic                   cmp_match;
    logic [AddrW-1:0]       addr_off;
    logic [RomTopCount-1:0] exp_we;

    assign addr_off = data_addr_i - TopStart;

    for (genvar gi = 0; gi < RomTopCount; gi++) begin : g_exp_we
        assign exp_we[gi] = capture_en && (addr_off == AddrW'(gi));
    end

    always_comb begin
        state_d     = state_q;
        kmac_vld_o  = 1'b0;
        kmac_data_o = '0;
        kmac_last_o = 1'b0;
        data_rdy_o  = 1'b0;
        done_o      = 1'b0;
        good_o      = 1'b0;
        alert_o     = 1'b0;
        capture_en  = 1'b0;
        dig_accept  = 1'b0;
        cmp_start   = 1'b0;

        case (state_q)
            FsHashing: begin
                kmac_vld_o  = rom_vld_i;
                kmac_data_o = rom_data_i;
                kmac_last_o = rom_vld_i & data_last_nontop_i;
                data_rdy_o  = kmac_rdy_i;
                if (kmac_vld_o && kmac_rdy_i && kmac_last_o) begin
                    state_d = FsReadTop;
                end
                if (kmac_digest_vld_i || ctr_done_i) begin
                    state_d = FsError;
                end
            end
            FsReadTop: begin
                data_rdy_o = 1'b1;
                capture_en = rom_vld_i && (data_addr_i >= TopStart);
                dig_accept = kmac_digest_vld_i && !dig_valid_q;
                if (ctr_done_i) begin
                    state_d = FsWaitDigest;
                end
            end
            FsWaitDigest: begin
                dig_accept = kmac_digest_vld_i && !dig_valid_q;
                if (dig_valid_q || dig_accept) begin
                    state_d = FsCompare;
                end
            end
            FsCompare: begin
                cmp_start = 1'b1;
                if (cmp_done) begin
                    state_d = FsDone;
                end
            end
            FsDone: begin
                done_o = 1'b1;
                good_o = cmp_match;
            end
            FsError: begin
                done_o  = 1'b1;
                alert_o = 1'b1;
            end
            default: state_d = FsError;
        endcase

        // Once the counter has reported done it must keep reporting it.
        if (state_q != FsDone && state_q != FsError && ctr_done_seen_q && !ctr_done_i) begin
            state_d = FsError;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= FsHashing;
            exp_q           <= '0;
            dig_q           <= '0;
            dig_valid_q     <= 1'b0;
            ctr_done_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < RomTopCount; i++) begin
                if (exp_we[i]) begin
                    exp_q[i] <= rom_data_i;
                end
            end
            if (dig_accept) begin
                dig_q       <= kmac_digest_i;
                dig_valid_q <= 1'b1;
            end
            if (ctr_done_i) begin
                ctr_done_seen_q <= 1'b1;
            end
        end
    end

    rom_ctrl_digest_cmp #(
        .Words (RomTopCount),
        .Width (DataWidth)
    ) u_cmp (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (cmp_start),
        .exp_i   (exp_q),
        .dig_i   (dig_q),
        .done_o  (cmp_done),
        .match_o (cmp_match)
    );

endmodule

// File: tb/tb_rom_ctrl_hash_feeder.sv
// Bench for rom_ctrl_hash_feeder: table of full runs against a digest model,
// plus hand sequences for error and reset corner cases.
module tb_rom_ctrl_hash_feeder;

    localparam int Depth  = 16;
    localparam int Top    = 8;
    localparam int DW     = 32;
    localparam int NonTop = Depth - Top;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [DW-1:0]     rom_data_i;
    logic              rom_vld_i;
    logic [3:0]        data_addr_i;
    logic              data_last_nontop_i;
    logic              ctr_done_i;
    logic              data_rdy_o;
    logic              kmac_vld_o;
    logic [DW-1:0]     kmac_data_o;
    logic              kmac_last_o;
    logic              kmac_rdy_i;
    logic              kmac_digest_vld_i;
    logic [Top*DW-1:0] kmac_digest_i;
    logic              done_o;
    logic              good_o;
    logic              alert_o;

    always #5 clk_i = ~clk_i;

    rom_ctrl_hash_feeder #(
        .RomDepth    (Depth),
        .RomTopCount (Top),
        .DataWidth   (DW)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .rom_data_i         (rom_data_i),
        .rom_vld_i          (rom_vld_i),
        .data_addr_i        (data_addr_i),
        .data_last_nontop_i (data_last_nontop_i),
        .ctr_done_i         (ctr_done_i),
        .data_rdy_o         (data_rdy_o),
        .kmac_vld_o         (kmac_vld_o),
        .kmac_data_o        (kmac_data_o),
        .kmac_last_o        (kmac_last_o),
        .kmac_rdy_i         (kmac_rdy_i),
        .kmac_digest_vld_i  (kmac_digest_vld_i),
        .kmac_digest_i      (kmac_digest_i),
        .done_o             (done_o),
        .good_o             (good_o),
        .alert_o            (alert_o)
    );

    typedef struct {
        int rom_mode;     // 0: word k holds k, 1: random contents
        int rdy_mode;     // 0: always ready, 1: 1,0,0,1 pattern, 2: random
        int corrupt_idx;  // digest word replaced by DEADBEEF, -1 for none
        bit early;        // digest delivered while top words are still being read
        int exp_good;     // 0/1 fixed expectation, 2: take it from the model
    } row_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rom_mem   [Depth];
    logic [31:0] dig_words [Top];
    row_t        rows      [10];

    bit          in_hash = 1'b0;
    bit          in_top  = 1'b0;
    logic [31:0] rx_q [$];
    bit          rxl_q [$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        rom_data_i         = '0;
        rom_vld_i          = 1'b0;
        data_addr_i        = '0;
        data_last_nontop_i = 1'b0;
        ctr_done_i         = 1'b0;
        kmac_rdy_i         = 1'b0;
        kmac_digest_vld_i  = 1'b0;
        kmac_digest_i      = '0;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctrl"}, 64'({kmac_vld_o, kmac_last_o, data_rdy_o, done_o, good_o, alert_o}), 64'(0));
        chk({nm, "_data"}, 64'(kmac_data_o), 64'(0));
    endtask

    // Message-side monitor: scoreboard of accepted words and stall stability.
    always @(negedge clk_i) begin
        if (rst_ni && in_hash) begin
            chk("data_rdy_mirror", 64'(data_rdy_o), 64'(kmac_rdy_i));
            if (prev_stall) begin
                chk("stall_vld_held", 64'(kmac_vld_o), 64'(1));
                chk("stall_data_stable", 64'(kmac_data_o), 64'(prev_data));
            end
            if (kmac_vld_o && kmac_rdy_i) begin
                rx_q.push_back(kmac_data_o);
                rxl_q.push_back(kmac_last_o);
            end
            prev_stall <= kmac_vld_o && !kmac_rdy_i;
            prev_data  <= kmac_data_o;
        end else begin
            prev_stall <= 1'b0;
        end
        if (rst_ni && in_top) begin
            chk("readtop_no_vld", 64'(kmac_vld_o), 64'(0));
        end
    end

    // Plays the ROM counter for the first n words; each word is held until taken.
    task automatic drive_hash(input int n, input int mode);
        int cyc    = 0;
        int stalls = 0;
        bit r;
        for (int k = 0; k < n; k++) begin
            rom_vld_i          = 1'b1;
            rom_data_i         = rom_mem[k];
            data_addr_i        = 4'(k);
            data_last_nontop_i = (k == NonTop - 1);
            do begin
                case (mode)
                    0:       r = 1'b1;
                    1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: r = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                endcase
                stalls     = r ? 0 : stalls + 1;
                cyc++;
                kmac_rdy_i = r;
                tick();
            end while (!r);
        end
        rom_vld_i          = 1'b0;
        data_last_nontop_i = 1'b0;
        kmac_rdy_i         = 1'b0;
    endtask

    task automatic drive_top(input bit early);
        in_top = 1'b1;
        for (int k = NonTop; k < Depth; k++) begin
            rom_vld_i         = 1'b1;
            data_addr_i       = 4'(k);
            rom_data_i        = rom_mem[k];
            ctr_done_i        = (k == Depth - 1);
            kmac_digest_vld_i = early && (k == NonTop + 2);
            tick();
        end
        rom_vld_i         = 1'b0;
        kmac_digest_vld_i = 1'b0;
        in_top            = 1'b0;
    endtask

    task automatic prepare(input row_t r, output bit model_good);
        for (int k = 0; k < Depth; k++) begin
            rom_mem[k] = (r.rom_mode == 0) ? 32'(k) : $urandom();
        end
        for (int i = 0; i < Top; i++) begin
            dig_words[i] = rom_mem[NonTop + i];
        end
        if (r.corrupt_idx >= 0) begin
            dig_words[r.corrupt_idx] = 32'hDEAD_BEEF;
        end
        model_good = 1'b1;
        for (int i = 0; i < Top; i++) begin
            if (dig_words[i] != rom_mem[NonTop + i]) model_good = 1'b0;
        end
        for (int i = 0; i < Top; i++) begin
            kmac_digest_i[i*DW +: DW] = dig_words[i];
        end
    endtask

    task automatic run_row(input row_t r, input int ri);
        bit model_good;
        bit exp_good;
        apply_reset();
        prepare(r, model_good);
        exp_good = (r.exp_good == 2) ? model_good : r.exp_good[0];
        rx_q.delete();
        rxl_q.delete();
        in_hash = 1'b1;
        drive_hash(NonTop, r.rdy_mode);
        in_hash = 1'b0;
        drive_top(r.early);
        if (r.early) begin
            // WaitDigest entered on the last edge; compare starts on the next one.
            repeat (8) tick();
            chk("done_latency_early_lo", 64'(done_o), 64'(0));
            tick();
            chk("done_latency_early_hi", 64'(done_o), 64'(1));
        end else begin
            tick();
            kmac_digest_vld_i = 1'b1;
            tick();
            kmac_digest_vld_i = 1'b0;
            repeat (7) tick();
            chk("done_latency_lo", 64'(done_o), 64'(0));
            tick();
            chk("done_latency_hi", 64'(done_o), 64'(1));
        end
        chk("good", 64'(good_o), 64'(exp_good));
        chk("alert_clean", 64'(alert_o), 64'(0));
        chk("msg_count", 64'(rx_q.size()), 64'(NonTop));
        for (int k = 0; k < NonTop && k < rx_q.size(); k++) begin
            chk("msg_word", 64'(rx_q[k]), 64'(rom_mem[k]));
            chk("msg_last", 64'(rxl_q[k]), 64'(k == NonTop - 1));
        end
        $display("row %0d: rdy_mode=%0d corrupt=%0d early=%0b words=%0d -> done=%0b good=%0b (exp %0b) alert=%0b",
                 ri, r.rdy_mode, r.corrupt_idx, r.early, rx_q.size(), done_o, good_o, exp_good, alert_o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit dummy;
        rows[0] = '{0, 0, -1, 1'b0, 1};
        rows[1] = '{0, 0,  5, 1'b0, 0};
        rows[2] = '{0, 1, -1, 1'b0, 1};
        rows[3] = '{0, 0, -1, 1'b1, 1};
        for (int i = 4; i < 10; i++) begin
            rows[i] = '{1, 2, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, Top - 1)) : -1,
                        1'($urandom_range(0, 1)), 2};
        end

        rst_ni = 1'b0;
        idle_inputs();
        tick();
        chk_all_zero("reset_state");
        $display("reset: ctrl=%b data=%0h", {kmac_vld_o, kmac_last_o, data_rdy_o, done_o, good_o, alert_o}, kmac_data_o);

        for (int i = 0; i < 10; i++) begin
            run_row(rows[i], i);
        end

        // Digest pulse while still hashing.
        apply_reset();
        prepare(rows[0], dummy);
        in_hash = 1'b1;
        drive_hash(3, 0);
        in_hash = 1'b0;
        kmac_digest_vld_i = 1'b1;
        chk("early_digest_pre_alert", 64'(alert_o), 64'(0));
        tick();
        kmac_digest_vld_i = 1'b0;
        chk("early_digest_alert", 64'(alert_o), 64'(1));
        chk("early_digest_done", 64'(done_o), 64'(1));
        chk("early_digest_good", 64'(good_o), 64'(0));
        repeat (3) tick();
        chk("early_digest_sticky", 64'(alert_o), 64'(1));
        $display("seq digest-in-hashing: alert=%0b done=%0b good=%0b", alert_o, done_o, good_o);

        // ctr_done held two cycles then dropped.
        apply_reset();
        prepare(rows[0], dummy);
        drive_hash(NonTop, 0);
        drive_top(1'b0);
        tick();
        chk("ctr_drop_pre_alert", 64'(alert_o), 64'(0));
        ctr_done_i = 1'b0;
        tick();
        chk("ctr_drop_alert", 64'(alert_o), 64'(1));
        chk("ctr_drop_done", 64'(done_o), 64'(1));
        chk("ctr_drop_good", 64'(good_o), 64'(0));
        $display("seq ctr_done drop: alert=%0b done=%0b good=%0b", alert_o, done_o, good_o);

        // Reset asserted in the middle of the comparison.
        apply_reset();
        prepare(rows[0], dummy);
        drive_hash(NonTop, 0);
        drive_top(1'b0);
        tick();
        kmac_digest_vld_i = 1'b1;
        tick();
        kmac_digest_vld_i = 1'b0;
        repeat (3) tick();
        chk("mid_compare_not_done", 64'(done_o), 64'(0));
        rst_ni = 1'b0;
        idle_inputs();
        #1;
        chk_all_zero("mid_compare_reset");
        $display("seq reset mid-compare: ctrl=%b", {kmac_vld_o, kmac_last_o, data_rdy_o, done_o, good_o, alert_o});
        tick();
        run_row(rows[0], 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
